fifo_uart: RTL and testbench

Buffered, parametrised successor to the SoC's simple UART. It is a PicoRV32 native-bus slave with TX and RX FIFOs of configurable depth, a status register with sticky error flags, and an interrupt output. It is decoded at BASE_ADDR in the IO region, and the SoC ORs its mem_ready into the CPU ready and muxes its mem_rdata.

---
 rtl/fifo_uart_if.sv | 26 ++
 rtl/fifo_uart.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_fifo_uart.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_if.sv
// fifo_uart_if -- PicoRV32 native memory bus, as seen by one peripheral.
//   mem_valid  : CPU request valid
//   mem_addr   : byte address
//   mem_wdata  : write data
//   mem_wstrb  : byte strobes, 0 = read
//   mem_ready  : one-cycle acknowledge from the peripheral
//   mem_rdata  : read data, valid while mem_ready is high
// master = CPU / bus driver, slave = peripheral.
interface fifo_uart_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/fifo_uart.sv
// fifo_uart -- buffered UART with TX/RX FIFOs on the PicoRV32 native bus.
// Registers (word offsets from BASE_ADDR):
//   +0x0 DIV     clk cycles per bit, byte-writable, effective value max(DIV,2)
//   +0x4 DATA    write pushes TX byte; read pops RX byte (0xFFFF_FFFF if empty)
//   +0x8 STATUS  [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                [4] rx_overrun [5] frame_err [6] tx_drop (sticky, W1C)
//                [7] tx_busy [23:16] rx_count [31:24] tx_count
//   +0xC CTRL    [0] rx_irq_en [1] tx_irq_en [2] err_irq_en
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : native bus slave (single-cycle registered acknowledge)
//   irq        : registered level interrupt
//   ser_tx     : serial output, idle high
//   ser_rx     : serial input, asynchronous to clk
module fifo_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h0200_0010,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'd104
) (
  input  logic       clk,
  input  logic       reset,
  fifo_uart_if.slave bus,
  output logic       irq,
  output logic       ser_tx,
  input  logic       ser_rx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] R_DIV    = 2'd0;
  localparam logic [1:0] R_DATA   = 2'd1;
  localparam logic [1:0] R_STATUS = 2'd2;
  localparam logic [1:0] R_CTRL   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  function automatic logic [7:0] sat8(input logic [PW-1:0] c);
    logic [8:0] e;
    e = 9'(c);
    return e[8] ? 8'hFF : e[7:0];
  endfunction

  // ---------------- bus decode ----------------
  logic       sel, wr, rd;
  logic [1:0] reg_sel;
  logic       unused_addr;

  assign sel         = bus.mem_valid && (bus.mem_addr[31:4] == BASE_ADDR[31:4]) && !bus.mem_ready;
  assign wr          = sel && (bus.mem_wstrb != 4'b0000);
  assign rd          = sel && (bus.mem_wstrb == 4'b0000);
  assign reg_sel     = bus.mem_addr[3:2];
  assign unused_addr = ^bus.mem_addr[1:0];

  logic [31:0] div_reg, eff_div;
  logic [2:0]  ctrl;
  logic        rx_overrun, frame_err, tx_drop;

  assign eff_div = (div_reg < 32'd2) ? 32'd2 : div_reg;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp, tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_drop_set;

  assign tx_empty    = tx_wp == tx_rp;
  assign tx_full     = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
  assign tx_count    = tx_wp - tx_rp;
  assign tx_push     = wr && (reg_sel == R_DATA) && bus.mem_wstrb[0] && !tx_full;
  assign tx_drop_set = wr && (reg_sel == R_DATA) && bus.mem_wstrb[0] && tx_full;

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp, rx_count;
  logic          rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0]    rx_head;

  assign rx_empty = rx_wp == rx_rp;
  assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
  assign rx_count = rx_wp - rx_rp;
  assign rx_pop   = rd && (reg_sel == R_DATA) && !rx_empty;
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + PW'(1);
      if (tx_pop)  tx_rp <= tx_rp + PW'(1);
      if (rx_push) rx_wp <= rx_wp + PW'(1);
      if (rx_pop)  rx_rp <= rx_rp + PW'(1);
    end
  end

  // NOTE: FIFO storage is deliberately left out of reset; the pointers alone
  // define which entries are valid, and an unreset array maps onto RAM.
  logic [7:0] rx_shift;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.mem_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
  end

  // ---------------- TX FSM ----------------
  uart_state_e tx_state, tx_state_nxt;
  logic [31:0] tx_div, tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_bit_end, tx_busy, tx_line;

  assign tx_bit_end = tx_cnt == (tx_div - 32'd1);
  assign tx_pop     = (tx_state == S_IDLE) && !tx_empty;
  assign tx_busy    = tx_state != S_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tx_state <= S_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:  if (!tx_empty)                    tx_state_nxt = S_START;
      S_START: if (tx_bit_end)                   tx_state_nxt = S_DATA;
      S_DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_state_nxt = S_STOP;
      default: if (tx_bit_end)                   tx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_shift[0];
      default: tx_line = 1'b1;
    endcase
  end

  // The divider is re-latched at every bit boundary so DIV writes never
  // stretch or shrink a bit already on the wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_div   <= 32'd2;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      ser_tx   <= 1'b1;
    end else begin
      ser_tx <= tx_line;
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rp[AW-1:0]];
        tx_cnt   <= '0;
        tx_div   <= eff_div;
        tx_bit   <= '0;
      end else if (tx_busy) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          tx_div <= eff_div;
          if (tx_state == S_DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + 32'd1;
        end
      end
    end
  end

  // ---------------- RX synchroniser + FSM ----------------
  logic        rx_s1, rx_s2;
  uart_state_e rx_state, rx_state_nxt;
  logic [31:0] rx_div, rx_cnt;
  logic [2:0]  rx_bit;
  logic        rx_done;        // stop bit already sampled, waiting for idle line
  logic        rx_half, rx_bit_end, rx_stop_sample;
  logic        rx_overrun_set, frame_err_set;

  assign rx_half        = rx_cnt == (rx_div >> 1);
  assign rx_bit_end     = rx_cnt == (rx_div - 32'd1);
  assign rx_stop_sample = (rx_state == S_STOP) && !rx_done && rx_bit_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_state <= S_IDLE;
    end else begin
      rx_s1    <= ser_rx;
      rx_s2    <= rx_s1;
      rx_state <= rx_state_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:  if (!rx_s2)  rx_state_nxt = S_START;
      S_START: if (rx_half) rx_state_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_state_nxt = S_STOP;
      default: if ((rx_done || rx_bit_end) && rx_s2) rx_state_nxt = S_IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  always_comb begin
    rx_push        = rx_stop_sample && rx_s2 && (!rx_full || rx_pop);
    rx_overrun_set = rx_stop_sample && rx_s2 && rx_full && !rx_pop;
    frame_err_set  = rx_stop_sample && !rx_s2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_div   <= 32'd2;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_cnt  <= '0;
          rx_div  <= eff_div;
          rx_bit  <= '0;
          rx_done <= 1'b0;
        end
        S_START: begin
          if (rx_half) begin
            rx_cnt <= '0;
            rx_div <= eff_div;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            rx_cnt   <= '0;
            rx_div   <= eff_div;
          end else begin
            rx_cnt <= rx_cnt + 32'd1;
          end
        end
        default: begin
          if (!rx_done) begin
            if (rx_bit_end) rx_done <= 1'b1;
            else            rx_cnt  <= rx_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  // ---------------- registers, read mux, irq ----------------
  logic [31:0] status, rdata_mux;
  logic [2:0]  sticky_clr;

  assign status = {sat8(tx_count), sat8(rx_count), 8'h00,
                   tx_busy, tx_drop, frame_err, rx_overrun,
                   rx_empty, rx_full, tx_empty, tx_full};

  assign sticky_clr = (wr && reg_sel == R_STATUS && bus.mem_wstrb[0]) ? bus.mem_wdata[6:4] : 3'b000;

  always_comb begin
    rdata_mux = 32'h0;
    case (reg_sel)
      R_DIV:    rdata_mux = div_reg;
      R_DATA:   rdata_mux = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_head};
      R_STATUS: rdata_mux = status;
      default:  rdata_mux = {29'h0, ctrl};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg       <= DEFAULT_DIV;
      ctrl          <= '0;
      rx_overrun    <= 1'b0;
      frame_err     <= 1'b0;
      tx_drop       <= 1'b0;
      irq           <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= sel;
      bus.mem_rdata <= rd ? rdata_mux : 32'h0;
      if (wr && reg_sel == R_DIV) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_wstrb[b]) div_reg[8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end
      if (wr && reg_sel == R_CTRL && bus.mem_wstrb[0]) ctrl <= bus.mem_wdata[2:0];
      // Set wins over a simultaneous write-1-to-clear.
      rx_overrun <= rx_overrun_set | (rx_overrun & ~sticky_clr[0]);
      frame_err  <= frame_err_set  | (frame_err  & ~sticky_clr[1]);
      tx_drop    <= tx_drop_set    | (tx_drop    & ~sticky_clr[2]);
      irq <= (ctrl[0] & !rx_empty) |
             (ctrl[1] & tx_empty & !tx_busy) |
             (ctrl[2] & (rx_overrun | frame_err | tx_drop));
    end
  end
endmodule

// File: tb/tb_fifo_uart.sv
// tb_fifo_uart -- self-checking bench for fifo_uart.
// Register-level vectors come from a table; serial traffic is tracked by
// scoreboards (tx_q decoded off ser_tx by a monitor, rx_q popped on DATA reads).
module tb_fifo_uart;
  localparam logic [31:0] BASE     = 32'h0200_0010;
  localparam int          DEPTH    = 16;
  localparam logic [31:0] A_DIV    = BASE;
  localparam logic [31:0] A_DATA   = BASE + 32'h4;
  localparam logic [31:0] A_STATUS = BASE + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset, irq, ser_tx, ser_rx;

  fifo_uart_if bus();

  fifo_uart #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(32'd104)) dut (
    .clk(clk), .reset(reset), .bus(bus), .irq(irq), .ser_tx(ser_tx), .ser_rx(ser_rx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- bus access ----------------
  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
    string       name;
  } exp_t;
  exp_t rd_q[$];

  task automatic bus_cycle(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output logic [31:0] rdata);
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    @(negedge clk);
    check("ack", 32'(bus.mem_ready), 32'd1);
    rdata = bus.mem_rdata;
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [31:0] r;
    bus_cycle(addr, wdata, wstrb, r);
  endtask

  task automatic bus_read_expect(input logic [31:0] addr, input logic [31:0] exp,
                                 input logic [31:0] mask, input string name);
    logic [31:0] r;
    exp_t e;
    rd_q.push_back('{val: exp, mask: mask, name: name});
    bus_cycle(addr, 32'h0, 4'h0, r);
    e = rd_q.pop_front();
    check(e.name, r & e.mask, e.val & e.mask);
  endtask

  // ---------------- RX side: driver + scoreboard ----------------
  logic [7:0] rx_q[$];

  task automatic send_rx(input logic [7:0] b, input logic stop, input int div);
    ser_rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = b[i];
      repeat (div) @(negedge clk);
    end
    ser_rx = stop;
    repeat (div) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic read_rx(input string name);
    logic [31:0] exp;
    if (rx_q.size() != 0) exp = {24'h0, rx_q.pop_front()};
    else                  exp = 32'hFFFF_FFFF;
    bus_read_expect(A_DATA, exp, 32'hFFFF_FFFF, name);
  endtask

  // ---------------- TX side: monitor + scoreboard ----------------
  logic [7:0] tx_q[$];
  int tx_frames = 0;
  bit mon_en    = 1'b0;
  int mon_div   = 8;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && ser_tx === 1'b0) begin : decode
        logic [7:0] b;
        logic [7:0] e;
        repeat (mon_div / 2) @(negedge clk);
        check("tx start bit", 32'(ser_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (mon_div) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (mon_div) @(negedge clk);
        check("tx stop bit", 32'(ser_tx), 32'd1);
        if (tx_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL tx unexpected byte: got 0x%02h expected none", b);
        end else begin
          e = tx_q.pop_front();
          check("tx byte", 32'(b), 32'(e));
        end
        tx_frames++;
      end
    end
  end

  // Counts start bits when every byte is 0xFF (one falling edge per frame).
  int   fall_cnt = 0;
  logic prev_tx  = 1'b1;
  always @(negedge clk) begin
    if (prev_tx === 1'b1 && ser_tx === 1'b0) fall_cnt++;
    prev_tx = ser_tx;
  end

  // ---------------- register vector table ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic        drained;
    logic        ready_seen;

    vecs[0]  = '{A_DIV,    32'h0,         4'h0, 32'd104,       32'hFFFF_FFFF, "div reset"};
    vecs[1]  = '{A_STATUS, 32'h0,         4'h0, 32'h0000_000A, 32'hFFFF_FFFF, "status reset"};
    vecs[2]  = '{A_CTRL,   32'h0,         4'h0, 32'h0,         32'hFFFF_FFFF, "ctrl reset"};
    vecs[3]  = '{A_DATA,   32'h0,         4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "data empty"};
    vecs[4]  = '{A_DIV,    32'h0000_000A, 4'h1, 32'h0,         32'h0,         "div wr byte0"};
    vecs[5]  = '{A_DIV,    32'h0,         4'h0, 32'h0000_000A, 32'hFFFF_FFFF, "div byte0"};
    vecs[6]  = '{A_DIV,    32'h1234_5678, 4'hF, 32'h0,         32'h0,         "div wr word"};
    vecs[7]  = '{A_DIV,    32'h00CD_0000, 4'h4, 32'h0,         32'h0,         "div wr byte2"};
    vecs[8]  = '{A_DIV,    32'h0,         4'h0, 32'h12CD_5678, 32'hFFFF_FFFF, "div byte2"};
    vecs[9]  = '{A_CTRL,   32'hFFFF_FFFF, 4'hF, 32'h0,         32'h0,         "ctrl wr ones"};
    vecs[10] = '{A_CTRL,   32'h0,         4'h0, 32'h0000_0007, 32'hFFFF_FFFF, "ctrl mask"};
    vecs[11] = '{A_CTRL,   32'h0,         4'hF, 32'h0,         32'h0,         "ctrl wr zero"};
    vecs[12] = '{A_CTRL,   32'h0,         4'h0, 32'h0,         32'hFFFF_FFFF, "ctrl clear"};

    reset         = 1'b1;
    ser_rx        = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    repeat (3) @(negedge clk);
    check("reset ser_tx", 32'(ser_tx), 32'd1);
    check("reset irq", 32'(irq), 32'd0);
    check("reset mem_ready", 32'(bus.mem_ready), 32'd0);
    check("reset mem_rdata", bus.mem_rdata, 32'h0);
    reset = 1'b0;

    // ---- reset values and DIV/CTRL registers ----
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wstrb != 4'h0) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
      else bus_read_expect(vecs[i].addr, vecs[i].exp, vecs[i].mask, vecs[i].name);
    end
    check("ser_tx idle", 32'(ser_tx), 32'd1);

    // ---- an address outside the block is never acknowledged ----
    @(negedge clk);
    bus.mem_valid = 1'b1;
    bus.mem_addr  = BASE + 32'h10;
    bus.mem_wstrb = 4'h0;
    ready_seen    = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ready_seen = ready_seen | bus.mem_ready;
    end
    bus.mem_valid = 1'b0;
    check("no ack off-range", 32'(ready_seen), 32'd0);

    // ---- TX: two frames at DIV=8 ----
    bus_write(A_DIV, 32'd8, 4'hF);
    mon_div = 8;
    mon_en  = 1'b1;
    tx_q.push_back(8'h55);
    bus_write(A_DATA, 32'h55, 4'h1);
    tx_q.push_back(8'hA3);
    bus_write(A_DATA, 32'hA3, 4'h1);
    bus_read_expect(A_STATUS, 32'h0100_0080, 32'hFF00_0083, "tx count one");
    for (int i = 0; i < 400 && tx_frames < 2; i++) @(negedge clk);
    check("tx frames", 32'(tx_frames), 32'd2);
    repeat (8) @(negedge clk);
    bus_read_expect(A_STATUS, 32'h0000_0002, 32'hFF00_0083, "tx drained");
    mon_en = 1'b0;

    // ---- TX full: slow divider so the FIFO fills before the first bit ends ----
    bus_write(A_DIV, 32'd4096, 4'hF);
    fall_cnt = 0;
    for (int i = 0; i < DEPTH + 2; i++) bus_write(A_DATA, 32'hFF, 4'h1);
    bus_read_expect(A_STATUS, 32'h1000_00C1, 32'hFF00_00C3, "tx full drop");
    bus_write(A_STATUS, 32'h40, 4'h1);
    bus_read_expect(A_STATUS, 32'h1000_0081, 32'hFF00_00C3, "tx drop clear");
    bus_write(A_DIV, 32'd4, 4'hF);
    drained = 1'b0;
    for (int i = 0; i < 3000 && !drained; i++) begin
      bus_cycle(A_STATUS, 32'h0, 4'h0, r);
      drained = r[1] && !r[7];
    end
    check("tx full drained", 32'(drained), 32'd1);
    repeat (4) @(negedge clk);
    check("tx full frames", 32'(fall_cnt), 32'(DEPTH + 1));

    // ---- RX: two bytes, then empty, then a glitch ----
    bus_write(A_DIV, 32'd16, 4'hF);
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 16);
    repeat (4) @(negedge clk);
    rx_q.push_back(8'hFF);
    send_rx(8'hFF, 1'b1, 16);
    repeat (4) @(negedge clk);
    read_rx("rx byte 3c");
    read_rx("rx byte ff");
    read_rx("rx empty read");
    ser_rx = 1'b0;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read_expect(A_STATUS, 32'h0000_0008, 32'h00FF_003C, "rx glitch ignored");

    // ---- RX errors: bad stop bit, then overrun ----
    send_rx(8'hA5, 1'b0, 16);
    repeat (16) @(negedge clk);
    bus_read_expect(A_STATUS, 32'h0000_0028, 32'h00FF_003C, "frame err");
    bus_write(A_STATUS, 32'h20, 4'h1);
    bus_read_expect(A_STATUS, 32'h0000_0008, 32'h00FF_003C, "frame err clear");
    for (int i = 0; i <= DEPTH; i++) begin
      logic [7:0] b;
      b = 8'(8'h10 + i);
      if (i < DEPTH) rx_q.push_back(b);
      send_rx(b, 1'b1, 16);
    end
    repeat (4) @(negedge clk);
    bus_read_expect(A_STATUS, 32'h0010_0014, 32'h00FF_003C, "rx overrun");
    for (int i = 0; i < DEPTH; i++) read_rx("rx fifo data");
    read_rx("rx fifo drained");
    bus_write(A_STATUS, 32'h70, 4'h1);

    // ---- IRQ ----
    bus_write(A_CTRL, 32'h1, 4'h1);
    repeat (3) @(negedge clk);
    check("irq rx idle", 32'(irq), 32'd0);
    rx_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1, 16);
    repeat (4) @(negedge clk);
    check("irq rx pending", 32'(irq), 32'd1);
    read_rx("irq rx data");
    repeat (2) @(negedge clk);
    check("irq rx cleared", 32'(irq), 32'd0);
    bus_write(A_CTRL, 32'h2, 4'h1);
    repeat (3) @(negedge clk);
    check("irq tx idle", 32'(irq), 32'd1);

    // ---- reset in the middle of a TX frame ----
    bus_write(A_CTRL, 32'h1, 4'h1);
    send_rx(8'h77, 1'b1, 16);
    repeat (4) @(negedge clk);
    check("irq before reset", 32'(irq), 32'd1);
    bus_write(A_DIV, 32'd8, 4'hF);
    bus_write(A_DATA, 32'h00, 4'h1);
    repeat (20) @(negedge clk);
    check("tx mid-frame low", 32'(ser_tx), 32'd0);
    reset = 1'b1;
    #1;
    check("async reset ser_tx", 32'(ser_tx), 32'd1);
    check("async reset irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read_expect(A_STATUS, 32'h0000_000A, 32'hFFFF_FFFF, "status after reset");
    bus_read_expect(A_DIV, 32'd104, 32'hFFFF_FFFF, "div after reset");
    read_rx("data after reset");
    repeat (20) @(negedge clk);
    check("ser_tx after reset", 32'(ser_tx), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
